// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the writeback stage and register file.
// Holds the default sizing, a clog2 helper that never returns zero, and the
// channel record used by the execute and writeback stages.
package wb_pkg;

    localparam int DEFAULT_DW     = 32;
    localparam int DEFAULT_DEPTH  = 32;
    localparam int DEFAULT_NUM_WR = 2;
    localparam int DEFAULT_NUM_RD = 2;

    // Address width for a given register count; a 1- or 2-entry file
    // still gets a 1-bit address so port vectors never collapse to zero.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEFAULT_AW = clog2_safe(DEFAULT_DEPTH);

    typedef struct packed {
        logic                  valid;
        logic [DEFAULT_AW-1:0] addr;
        logic [DEFAULT_DW-1:0] data;
    } wb_chan_t;

endpackage

// File: rtl/writeback_regfile_if.sv
// writeback_regfile_if: bundles the writeback channels, the issue-time
// reservation, the read ports and the debug/status outputs.
//   master : drives wb_valid/wb_addr/wb_data, rsv_valid/rsv_addr, rd_addr;
//            observes rd_data, rd_busy, busy, wr_conflict, retire_cnt
//   slave  : the register file side (directions reversed)
interface writeback_regfile_if
    import wb_pkg::*;
#(
    parameter int DW     = DEFAULT_DW,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int AW     = clog2_safe(DEPTH),
    parameter int NUM_WR = DEFAULT_NUM_WR,
    parameter int NUM_RD = DEFAULT_NUM_RD,
    parameter int CNT_W  = 16
);
    logic [NUM_WR-1:0]    wb_valid;
    logic [NUM_WR*AW-1:0] wb_addr;
    logic [NUM_WR*DW-1:0] wb_data;
    logic                 rsv_valid;
    logic [AW-1:0]        rsv_addr;
    logic [NUM_RD*AW-1:0] rd_addr;
    logic [NUM_RD*DW-1:0] rd_data;
    logic [NUM_RD-1:0]    rd_busy;
    logic [DEPTH-1:0]     busy;
    logic                 wr_conflict;
    logic [CNT_W-1:0]     retire_cnt;

    modport master (
        output wb_valid, wb_addr, wb_data, rsv_valid, rsv_addr, rd_addr,
        input  rd_data, rd_busy, busy, wr_conflict, retire_cnt
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, rsv_valid, rsv_addr, rd_addr,
        output rd_data, rd_busy, busy, wr_conflict, retire_cnt
    );

endinterface

// File: rtl/wb_merge.sv
// wb_merge: combinational priority resolution across writeback channels.
//   valid/addr/data : raw channel inputs
//   commit          : channel commits (valid and not a suppressed addr-0 write)
//   win_en          : channel is the highest-index committer to its address
//   win_data        : channel data, zeroed when the channel does not win
//   conflict        : two or more valid channels share an address
module wb_merge
    import wb_pkg::*;
#(
    parameter int DW       = DEFAULT_DW,
    parameter int AW       = DEFAULT_AW,
    parameter int NUM_WR   = DEFAULT_NUM_WR,
    parameter int ZERO_REG = 1
) (
    input  logic [NUM_WR-1:0]    valid,
    input  logic [NUM_WR*AW-1:0] addr,
    input  logic [NUM_WR*DW-1:0] data,
    output logic [NUM_WR-1:0]    commit,
    output logic [NUM_WR-1:0]    win_en,
    output logic [NUM_WR*DW-1:0] win_data,
    output logic                 conflict
);

    always_comb begin
        commit   = '0;
        win_en   = '0;
        win_data = '0;
        conflict = 1'b0;

        for (int i = 0; i < NUM_WR; i++) begin
            commit[i] = valid[i] &&
                        !((ZERO_REG != 0) && (addr[i*AW +: AW] == '0));
        end

        // A channel wins unless a higher-index committer hits the same
        // address. Collisions on a hardwired zero register are not
        // reported because nothing is actually written there.
        for (int i = 0; i < NUM_WR; i++) begin
            win_en[i] = commit[i];
            for (int k = i + 1; k < NUM_WR; k++) begin
                if (addr[i*AW +: AW] == addr[k*AW +: AW]) begin
                    if (commit[k]) begin
                        win_en[i] = 1'b0;
                    end
                    if (valid[i] && valid[k] &&
                        !((ZERO_REG != 0) && (addr[i*AW +: AW] == '0))) begin
                        conflict = 1'b1;
                    end
                end
            end
            if (win_en[i]) begin
                win_data[i*DW +: DW] = data[i*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile: multi-channel writeback into a DEPTH x DW register
// array with write-through read ports, a per-register busy scoreboard,
// a retire counter and a registered write-conflict flag.
//   clk   : sole clock
//   rst_n : asynchronous active-low reset
//   bus   : writeback_regfile_if slave port (channels, reservation,
//           read ports, busy/conflict/retire status)
module writeback_regfile
    import wb_pkg::*;
#(
    parameter int DW       = DEFAULT_DW,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AW       = clog2_safe(DEPTH),
    parameter int NUM_WR   = DEFAULT_NUM_WR,
    parameter int NUM_RD   = DEFAULT_NUM_RD,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input logic                clk,
    input logic                rst_n,
    writeback_regfile_if.slave bus
);

    logic [DW-1:0]        regs [DEPTH];
    logic [DEPTH-1:0]     busy_q;
    logic [DEPTH-1:0]     busy_next;
    logic                 conflict_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_inc;

    logic [NUM_WR-1:0]    gated_valid;
    logic [NUM_WR-1:0]    commit;
    logic [NUM_WR-1:0]    win_en;
    logic [NUM_WR*DW-1:0] win_data;
    logic                 conflict;

    // Writes are discarded while reset is held, which also keeps the
    // bypass path from showing write data on the read ports during reset.
    assign gated_valid = bus.wb_valid & {NUM_WR{rst_n}};

    wb_merge #(
        .DW       (DW),
        .AW       (AW),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_merge (
        .valid    (gated_valid),
        .addr     (bus.wb_addr),
        .data     (bus.wb_data),
        .commit   (commit),
        .win_en   (win_en),
        .win_data (win_data),
        .conflict (conflict)
    );

    // Scoreboard update: a commit clears, then a reservation sets, so a
    // same-cycle reservation keeps the register busy for its new producer.
    always_comb begin
        busy_next = busy_q;
        for (int r = 0; r < DEPTH; r++) begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (commit[i] && (bus.wb_addr[i*AW +: AW] == AW'(r))) begin
                    busy_next[r] = 1'b0;
                end
            end
            if (bus.rsv_valid && (bus.rsv_addr == AW'(r)) &&
                !((ZERO_REG != 0) && (r == 0))) begin
                busy_next[r] = 1'b1;
            end
        end
    end

    // Every committing channel retires, including ones shadowed by a
    // higher-index channel on the same address.
    always_comb begin
        cnt_inc = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            cnt_inc = cnt_inc + CNT_W'(commit[i]);
        end
    end

    // Array: at most one winner per address, so loop order is irrelevant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (win_en[i]) begin
                    regs[bus.wb_addr[i*AW +: AW]] <= win_data[i*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            busy_q     <= busy_next;
            conflict_q <= conflict;
            cnt_q      <= cnt_q + cnt_inc;
        end
    end

    // Read ports: the winning same-cycle write to the address overrides
    // the array; a hardwired zero register always reads 0.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            bus.rd_data[j*DW +: DW] = regs[bus.rd_addr[j*AW +: AW]];
            for (int i = 0; i < NUM_WR; i++) begin
                if (win_en[i] &&
                    (bus.wb_addr[i*AW +: AW] == bus.rd_addr[j*AW +: AW])) begin
                    bus.rd_data[j*DW +: DW] = win_data[i*DW +: DW];
                end
            end
            if ((ZERO_REG != 0) && (bus.rd_addr[j*AW +: AW] == '0)) begin
                bus.rd_data[j*DW +: DW] = '0;
            end
            bus.rd_busy[j] = busy_q[bus.rd_addr[j*AW +: AW]];
        end
    end

    assign bus.busy        = busy_q;
    assign bus.wr_conflict = conflict_q;
    assign bus.retire_cnt  = cnt_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: directed and randomized checks of writeback_regfile
// (two channels, two read ports, hardwired zero register, 4-bit retire
// counter) against a register-level reference model held in the bench.
module tb_writeback_regfile;

    localparam int DW     = 32;
    localparam int DEPTH  = 32;
    localparam int AW     = 5;
    localparam int NUM_WR = 2;
    localparam int NUM_RD = 2;
    localparam int CNT_W  = 4;

    logic clk;
    logic rst_n;

    writeback_regfile_if #(
        .DW(DW), .DEPTH(DEPTH), .AW(AW),
        .NUM_WR(NUM_WR), .NUM_RD(NUM_RD), .CNT_W(CNT_W)
    ) bus ();

    writeback_regfile #(
        .DW(DW), .DEPTH(DEPTH), .AW(AW), .NUM_WR(NUM_WR),
        .NUM_RD(NUM_RD), .ZERO_REG(1), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: register values, busy bits, retire count, conflict
    logic [31:0] model_regs [DEPTH];
    logic [31:0] model_busy;
    int          model_cnt;
    logic        model_conf;

    int total;
    int bad;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < DEPTH; r++) model_regs[r] = 32'h0;
        model_busy = 32'h0;
        model_cnt  = 0;
        model_conf = 1'b0;
    endtask

    // Value a read of register r must return this cycle, given the
    // channels being presented: register 0 is zero, the highest committing
    // channel to r wins, otherwise the stored value.
    function automatic logic [31:0] exp_rd(input logic [4:0] r, input logic [1:0] v,
                                           input logic [4:0] a0, input logic [4:0] a1,
                                           input logic [31:0] d0, input logic [31:0] d1);
        logic [31:0] e;
        if (r == 5'd0) return 32'h0;
        e = model_regs[r];
        if (v[0] && a0 == r) e = d0;
        if (v[1] && a1 == r) e = d1;
        return e;
    endfunction

    task automatic model_step(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic rv, input logic [4:0] ra);
        int n;
        n = 0;
        if (v[0] && a0 != 5'd0) begin
            model_regs[a0] = d0;
            model_busy[a0] = 1'b0;
            n++;
        end
        if (v[1] && a1 != 5'd0) begin
            model_regs[a1] = d1;
            model_busy[a1] = 1'b0;
            n++;
        end
        if (rv && ra != 5'd0) model_busy[ra] = 1'b1;
        model_conf = v[0] && v[1] && (a0 == a1) && (a0 != 5'd0);
        model_cnt  = (model_cnt + n) % (1 << CNT_W);
    endtask

    // One clock of stimulus: drive, check the combinational read ports,
    // take the edge, advance the model, check the registered outputs.
    task automatic apply_cycle(input logic [1:0] v,
                               input logic [4:0] a0, input logic [31:0] d0,
                               input logic [4:0] a1, input logic [31:0] d1,
                               input logic rv, input logic [4:0] ra,
                               input logic [4:0] r0, input logic [4:0] r1);
        bus.wb_valid  = v;
        bus.wb_addr   = {a1, a0};
        bus.wb_data   = {d1, d0};
        bus.rsv_valid = rv;
        bus.rsv_addr  = ra;
        bus.rd_addr   = {r1, r0};
        #1;
        check("rd_data0", bus.rd_data[31:0],  exp_rd(r0, v, a0, a1, d0, d1));
        check("rd_data1", bus.rd_data[63:32], exp_rd(r1, v, a0, a1, d0, d1));
        check("rd_busy0", 32'(bus.rd_busy[0]), 32'(model_busy[r0]));
        check("rd_busy1", 32'(bus.rd_busy[1]), 32'(model_busy[r1]));
        @(posedge clk);
        model_step(v, a0, a1, d0, d1, rv, ra);
        #1;
        check("busy",        bus.busy,               model_busy);
        check("wr_conflict", 32'(bus.wr_conflict),   32'(model_conf));
        check("retire_cnt",  32'(bus.retire_cnt),    32'(model_cnt));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        rst_n         = 1'b0;
        bus.wb_valid  = '0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        bus.rsv_valid = 1'b0;
        bus.rsv_addr  = '0;
        bus.rd_addr   = {5'd9, 5'd5};

        // Power-on reset
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_rd0",  bus.rd_data[31:0], 32'h0);
        check("reset_busy", bus.busy, 32'h0);
        check("reset_cnt",  32'(bus.retire_cnt), 32'h0);
        rst_n = 1'b1;

        // Dual write to distinct addresses, bypass then stored
        apply_cycle(2'b11, 5'd5, 32'h11, 5'd9, 32'h22, 1'b0, 5'd0, 5'd5, 5'd9);
        check("dual_cnt", 32'(bus.retire_cnt), 32'd2);
        apply_cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd9);
        check("dual_reg5", bus.rd_data[31:0],  32'h11);
        check("dual_reg9", bus.rd_data[63:32], 32'h22);

        // Same-address collision: channel 1 wins, conflict pulses once
        apply_cycle(2'b11, 5'd7, 32'hAA, 5'd7, 32'hBB, 1'b0, 5'd0, 5'd7, 5'd1);
        check("coll_conflict", 32'(bus.wr_conflict), 32'd1);
        apply_cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd5);
        check("coll_reg7", bus.rd_data[31:0], 32'hBB);
        check("coll_conflict_clear", 32'(bus.wr_conflict), 32'd0);

        // Zero register: write and reserve register 0
        apply_cycle(2'b01, 5'd0, 32'hDEAD, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
        check("zero_busy0", 32'(bus.busy[0]), 32'd0);
        check("zero_cnt",   32'(bus.retire_cnt), 32'd4);

        // Scoreboard: reserve, reserve+commit, then commit alone
        apply_cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
        check("sb_busy3_rsv", 32'(bus.busy[3]), 32'd1);
        apply_cycle(2'b10, 5'd0, 32'h0, 5'd3, 32'h5, 1'b1, 5'd3, 5'd3, 5'd0);
        check("sb_busy3_both", 32'(bus.busy[3]), 32'd1);
        apply_cycle(2'b01, 5'd3, 32'h6, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
        check("sb_busy3_clear", 32'(bus.busy[3]), 32'd0);

        // Reset mid-stream with both channels valid and a reservation
        bus.wb_valid  = 2'b11;
        bus.wb_addr   = {5'd9, 5'd5};
        bus.wb_data   = {32'h99, 32'h55};
        bus.rsv_valid = 1'b1;
        bus.rsv_addr  = 5'd4;
        bus.rd_addr   = {5'd9, 5'd5};
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_reset_rd0",  bus.rd_data[31:0],  32'h0);
        check("mid_reset_rd1",  bus.rd_data[63:32], 32'h0);
        check("mid_reset_busy", bus.busy, 32'h0);
        check("mid_reset_cnt",  32'(bus.retire_cnt), 32'h0);
        @(posedge clk);
        #1;
        check("held_reset_rd0",  bus.rd_data[31:0], 32'h0);
        check("held_reset_busy", bus.busy, 32'h0);
        check("held_reset_cnt",  32'(bus.retire_cnt), 32'h0);
        model_reset();
        rst_n = 1'b1;
        bus.wb_valid = 2'b00;
        bus.rd_addr  = {5'd9, 5'd5};
        #1;
        check("post_reset_rd0", bus.rd_data[31:0], 32'h0);

        // Counter wrap: 15 single commits then one dual commit
        for (int i = 0; i < 15; i++) begin
            apply_cycle(2'b01, 5'((i % 7) + 1), 32'(i + 100), 5'd0, 32'h0,
                        1'b0, 5'd0, 5'((i % 7) + 1), 5'd2);
        end
        check("wrap_pre", 32'(bus.retire_cnt), 32'd15);
        apply_cycle(2'b11, 5'd1, 32'h1234, 5'd2, 32'h5678, 1'b0, 5'd0, 5'd1, 5'd2);
        check("wrap_post", 32'(bus.retire_cnt), 32'd1);

        // Randomized traffic over a small address window to force
        // collisions, bypass hits and reserve/commit overlaps
        for (int n = 0; n < 200; n++) begin
            logic [1:0]  v;
            logic [4:0]  a0, a1, ra, r0, r1;
            logic [31:0] d0, d1;
            logic        rv;
            v  = 2'($urandom_range(0, 3));
            a0 = 5'($urandom_range(0, 7));
            a1 = 5'($urandom_range(0, 7));
            d0 = $urandom;
            d1 = $urandom;
            rv = 1'($urandom_range(0, 1));
            ra = 5'($urandom_range(0, 7));
            r0 = ($urandom_range(0, 1) == 1) ? a0 : 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 1) == 1) ? a1 : 5'($urandom_range(0, 7));
            apply_cycle(v, a0, d0, a1, d1, rv, ra, r0, r1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
